// File: rtl/data_mem_if.sv
// data_mem_if: request/response bundle between the load/store stage and the data memory.
//   master: the requester (pipeline stage or testbench) drives requests and rsp_ready.
//   slave : the memory drives req_ready and the response fields.
interface data_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

// File: rtl/data_mem_sized.sv
// data_mem_sized: word-organised data memory with byte/half/word access for the RV32 LSU.
//   clk         : clock, all state on posedge
//   reset       : synchronous, active-high
//   bus         : data_mem_if slave (valid/ready request, valid/ready response)
//   fault_count : saturating count of accepted requests that faulted
// Parameters:
//   ADDR_WIDTH   : word-address bits, capacity 2^ADDR_WIDTH 32-bit words
//   READ_LATENCY : 0 = combinational response, 1 = one-entry registered response
module data_mem_sized #(
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 0
) (
    input  logic        clk,
    input  logic        reset,
    data_mem_if.slave   bus,
    output logic [15:0] fault_count
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if (READ_LATENCY != 0 && READ_LATENCY != 1) begin : g_bad_latency
        $error("data_mem_sized: READ_LATENCY must be 0 or 1");
    end
    // The range check needs at least one address bit above the word index.
    if (ADDR_WIDTH < 1 || ADDR_WIDTH > 29) begin : g_bad_width
        $error("data_mem_sized: ADDR_WIDTH must be in 1..29");
    end

    logic [31:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            lane;
    logic                  fault;
    logic                  accept;
    logic [31:0]           rd_word;
    logic [31:0]           rd_shift;
    logic [31:0]           load_data;
    logic [31:0]           resp_data;
    logic [31:0]           wr_data;
    logic [3:0]            wr_be;
    logic [15:0]           fault_count_q;

    assign word_idx = bus.req_addr[ADDR_WIDTH+1:2];
    assign lane     = bus.req_addr[1:0];
    assign accept   = bus.req_valid && bus.req_ready;

    always_comb begin
        fault = 1'b0;
        if ((bus.req_addr >> (ADDR_WIDTH + 2)) != 32'd0) fault = 1'b1;
        unique case (bus.req_size)
            2'b00:   ;
            2'b01:   if (lane[0]) fault = 1'b1;
            2'b10:   if (lane != 2'b00) fault = 1'b1;
            default: fault = 1'b1;
        endcase
    end

    // Load path: align the addressed lane down to bit 0, then extend.
    assign rd_word  = mem[word_idx];
    assign rd_shift = rd_word >> {lane, 3'b000};

    always_comb begin
        load_data = 32'd0;
        unique case (bus.req_size)
            2'b00: load_data = bus.req_unsigned ? {24'd0, rd_shift[7:0]}
                                                : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01: load_data = bus.req_unsigned ? {16'd0, rd_shift[15:0]}
                                                : {{16{rd_shift[15]}}, rd_shift[15:0]};
            2'b10: load_data = rd_word;
            default: load_data = 32'd0;
        endcase
    end

    assign resp_data = (bus.req_we || fault) ? 32'd0 : load_data;

    // Store path: replicate the right-aligned data across lanes, select with byte enables.
    always_comb begin
        wr_data = bus.req_wdata;
        wr_be   = 4'b0000;
        unique case (bus.req_size)
            2'b00: begin
                wr_data = {4{bus.req_wdata[7:0]}};
                wr_be   = 4'b0001 << lane;
            end
            2'b01: begin
                wr_data = {2{bus.req_wdata[15:0]}};
                wr_be   = 4'b0011 << lane;
            end
            2'b10: begin
                wr_data = bus.req_wdata;
                wr_be   = 4'b1111;
            end
            default: begin
                wr_data = bus.req_wdata;
                wr_be   = 4'b0000;
            end
        endcase
    end

    // No reset on the array; accept is already blocked while reset is high.
    always_ff @(posedge clk) begin
        if (accept && bus.req_we && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fault_count_q <= 16'd0;
        end else if (accept && fault && fault_count_q != 16'hFFFF) begin
            fault_count_q <= fault_count_q + 16'd1;
        end
    end

    assign fault_count = fault_count_q;

    if (READ_LATENCY == 0) begin : g_comb
        assign bus.req_ready = bus.rsp_ready && !reset;
        assign bus.rsp_valid = bus.req_valid && !reset;
        assign bus.rsp_rdata = bus.rsp_valid ? resp_data : 32'd0;
        assign bus.rsp_fault = bus.rsp_valid && fault;
    end else begin : g_reg
        logic        rsp_valid_q;
        logic        rsp_fault_q;
        logic [31:0] rsp_rdata_q;

        // Accept whenever the single entry is empty or is being drained this cycle.
        assign bus.req_ready = !reset && (!rsp_valid_q || bus.rsp_ready);

        // resp_data samples the array before the same-edge store lands.
        always_ff @(posedge clk) begin
            if (reset) begin
                rsp_valid_q <= 1'b0;
                rsp_rdata_q <= 32'd0;
                rsp_fault_q <= 1'b0;
            end else if (accept) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= resp_data;
                rsp_fault_q <= fault;
            end else if (bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end

        assign bus.rsp_valid = rsp_valid_q;
        assign bus.rsp_rdata = rsp_rdata_q;
        assign bus.rsp_fault = rsp_fault_q;
    end
endmodule
